// File: rtl/wb_pkg.sv
// Shared write-back types: source-select codes, buffered entry layout and the data-select helper.
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // The reserved code 2'b11 falls through to the ALU result.
  function automatic logic [DATA_W-1:0] wb_select(input logic [1:0]        sel,
                                                  input logic [DATA_W-1:0] alu,
                                                  input logic [DATA_W-1:0] mem,
                                                  input logic [DATA_W-1:0] link);
    case (sel)
      WB_SEL_MEM:  wb_select = mem;
      WB_SEL_LINK: wb_select = link;
      default:     wb_select = alu;
    endcase
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending register writes; exposes every slot with its age (0 = oldest)
// so the forwarding logic can pick the youngest match.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_push,
  input  wb_entry_t                 i_entry,
  input  logic                      i_pop,
  output wb_entry_t                 o_head,
  output wb_entry_t [DEPTH-1:0]     o_entries,
  output logic [DEPTH-1:0]          o_valid,
  output logic [DEPTH-1:0][PW-1:0]  o_age,
  output logic [CW-1:0]             o_count
);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  // Local guards keep the count inside [0, DEPTH] whatever the caller does.
  assign w_push = i_push && (r_count < CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign o_age[gi]   = PW'(gi) - r_rd_ptr;
    assign o_valid[gi] = CW'(o_age[gi]) < r_count;
  end

  assign o_entries = r_mem;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/regfile_writeback.sv
// Write-back end of the register-file write port: selects result data, buffers pending writes,
// drains them on grant and serves youngest-match forwarding lookups.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic              rf_grant,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [ADDR_W-1:0] lk_rs1,
  input  logic [ADDR_W-1:0] lk_rs2,
  output logic              lk_hit1,
  output logic              lk_hit2,
  output logic [DATA_W-1:0] lk_data1,
  output logic [DATA_W-1:0] lk_data2,
  output logic [CW-1:0]     pending
);

  wb_entry_t                w_in_entry;
  wb_entry_t                w_head;
  wb_entry_t [DEPTH-1:0]    w_entries;
  logic [DEPTH-1:0]         w_valid;
  logic [DEPTH-1:0][PW-1:0] w_age;
  logic [CW-1:0]            w_count;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_head_vld;
  logic [1:0][ADDR_W-1:0]   w_lk_rs;
  logic [1:0]               w_lk_hit;
  logic [1:0][DATA_W-1:0]   w_lk_data;

  assign in_ready   = reset && (w_count < CW'(DEPTH));
  assign w_in_entry = '{rd: in_rd, data: wb_select(in_wb_sel, in_alu_result, in_mem_data, in_pc_plus4)};

  // Beats that never update a register are consumed without occupying a slot.
  assign w_push = in_valid && in_ready && in_reg_write && (in_rd != '0);

  // Gating with reset keeps every write-port output quiet while reset is held.
  assign w_head_vld    = reset && (w_count != '0);
  assign w_pop         = w_head_vld && rf_grant;
  assign rf_reg_write  = w_pop;
  assign rf_write_reg  = w_head_vld ? w_head.rd : '0;
  assign rf_write_data = w_head_vld ? w_head.data : '0;
  assign pending       = w_count;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_entry   (w_in_entry),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_age     (w_age),
    .o_count   (w_count)
  );

  assign w_lk_rs[0] = lk_rs1;
  assign w_lk_rs[1] = lk_rs2;

  // The head stays visible to lookups in the cycle it pops; the register file has not taken it yet.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
    logic              w_hit;
    logic [DATA_W-1:0] w_data;
    logic [PW-1:0]     w_best_age;

    always_comb begin
      w_hit      = 1'b0;
      w_data     = '0;
      w_best_age = '0;
      for (int s = 0; s < DEPTH; s++) begin
        if (reset && w_valid[s] && (w_lk_rs[gi] != '0) && (w_entries[s].rd == w_lk_rs[gi]) &&
            (!w_hit || (w_age[s] > w_best_age))) begin
          w_hit      = 1'b1;
          w_data     = w_entries[s].data;
          w_best_age = w_age[s];
        end
      end
    end

    assign w_lk_hit[gi]  = w_hit;
    assign w_lk_data[gi] = w_data;
  end

  assign lk_hit1  = w_lk_hit[0];
  assign lk_hit2  = w_lk_hit[1];
  assign lk_data1 = w_lk_data[0];
  assign lk_data2 = w_lk_data[1];

endmodule
